// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, counting
// direction, timebase FSM states and the counter turnaround value.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Center-aligned sequencing; edge-aligned counting stays in ST_UP.
  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_HOLD_TOP  = 2'd1,
    ST_DOWN      = 2'd2,
    ST_HOLD_ZERO = 2'd3
  } tbase_state_e;

  // Highest counter value: 2^width - 2, so a full-scale duty is always high.
  function automatic int unsigned calc_top(input int unsigned width);
    return (32'd1 << width) - 32'd2;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center counter with hold ticks,
// active-mode register and period boundary generation.
//   clk, clr     : clock, synchronous active-high clear
//   en           : run enable; when low the timebase parks at cnt=0, up
//   presc        : timebase steps once every presc+1 clocks
//   mode_in      : requested mode, adopted at a boundary or while en=0
//   cnt          : current counter value
//   period_tick  : registered one-clock pulse per period boundary
//   load_c       : combinational; active registers take shadow values this edge
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               mode_in,
  output logic [WIDTH-1:0]   cnt,
  output logic               period_tick,
  output logic               load_c
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(calc_top(WIDTH));

  tbase_state_e       state, state_nxt;
  logic [PRESC_W-1:0] pcnt, pcnt_nxt;
  logic [WIDTH-1:0]   cnt_nxt;
  logic               mode, mode_nxt;
  logic               tick_c, boundary_c, hold_c;
  dir_e               dir_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_UP;
      pcnt        <= '0;
      cnt         <= '0;
      mode        <= MODE_EDGE;
      period_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      pcnt        <= pcnt_nxt;
      cnt         <= cnt_nxt;
      mode        <= mode_nxt;
      period_tick <= boundary_c;
    end
  end

  // Next state: center mode dwells one tick at each turnaround
  always_comb begin
    state_nxt = state;
    if (!en || boundary_c) begin
      state_nxt = ST_UP;
    end else if (tick_c && (mode == MODE_CENTER)) begin
      case (state)
        ST_UP:        if (cnt == TOP) state_nxt = ST_HOLD_TOP;
        ST_HOLD_TOP:  state_nxt = ST_DOWN;
        ST_DOWN:      if (cnt == '0) state_nxt = ST_HOLD_ZERO;
        ST_HOLD_ZERO: state_nxt = ST_UP;
        default:      state_nxt = ST_UP;
      endcase
    end
  end

  // Outputs and counter datapath
  always_comb begin
    tick_c     = 1'b0;
    boundary_c = 1'b0;
    hold_c     = 1'b0;
    dir_c      = DIR_UP;
    load_c     = 1'b0;
    mode_nxt   = mode;
    pcnt_nxt   = pcnt;
    cnt_nxt    = cnt;

    // >= lets a lowered presc take effect without waiting for a wrap
    tick_c = en && (pcnt >= presc);
    dir_c  = ((state == ST_HOLD_TOP) || (state == ST_DOWN)) ? DIR_DOWN : DIR_UP;

    if (mode == MODE_EDGE) boundary_c = tick_c && (cnt == TOP);
    else                   boundary_c = tick_c && (state == ST_HOLD_ZERO);

    // First visit of TOP (going up) or 0 (going down) repeats the value once
    hold_c = (mode == MODE_CENTER) &&
             (((state == ST_UP) && (cnt == TOP)) || ((state == ST_DOWN) && (cnt == '0)));

    load_c   = !en || boundary_c;
    mode_nxt = load_c ? mode_in : mode;
    pcnt_nxt = (!en || tick_c) ? '0 : pcnt + PRESC_W'(1);

    if (!en) begin
      cnt_nxt = '0;
    end else if (boundary_c) begin
      // Center-to-center continues from 1; any mode change restarts at 0
      cnt_nxt = ((mode == MODE_CENTER) && (mode_in == MODE_CENTER)) ? WIDTH'(1) : '0;
    end else if (tick_c && !hold_c) begin
      cnt_nxt = (dir_c == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared timebase and double-buffered
// per-channel duty registers.
//   clk, clr     : clock, synchronous active-high clear
//   en           : run enable
//   presc        : prescaler reload value
//   mode_in      : 0 = edge-aligned, 1 = center-aligned (applied at period start)
//   duty_wr      : strobe writing duty_val into shadow[duty_ch]
//   duty_ch      : channel index; out-of-range indices are ignored
//   duty_val     : duty value
//   pwm_out      : registered PWM outputs
//   period_tick  : one-clock pulse at each period boundary
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESC_W  = 8,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [PRESC_W-1:0]  presc,
  input  logic                mode_in,
  input  logic                duty_wr,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [WIDTH-1:0]    duty_val,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  logic [WIDTH-1:0] cnt;
  logic             load_c;

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .presc       (presc),
    .mode_in     (mode_in),
    .cnt         (cnt),
    .period_tick (period_tick),
    .load_c      (load_c)
  );

  // Per-channel shadow/active duty and output compare
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow, active;
    logic             pwm_q;

    always_ff @(posedge clk) begin
      if (clr) begin
        shadow <= '0;
        active <= '0;
        pwm_q  <= 1'b0;
      end else begin
        // A write coinciding with a load reaches shadow only; active takes the old value
        if (duty_wr && (32'(duty_ch) == i)) shadow <= duty_val;
        if (load_c) active <= shadow;
        pwm_q <= en && (cnt < active);
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator, successor to the single-channel 8-bit switch-driven PWM. It has one shared timebase with a programmable prescaler and selectable edge- or center-aligned counting. Each channel has a double-buffered (shadow/active) duty register, so duty updates are glitch-free. It sits between the control/register logic and the pin drivers, and serves as the standard PWM source for motor, LED and audio outputs.

Parameters:
WIDTH, 8, counter and duty width in bits; TOP = 2^WIDTH - 2.
CHANNELS, 4, number of independent PWM outputs.
PRESC_W, 8, prescaler value width.
CH_W, max(1, $clog2(CHANNELS)), channel-select width (derived).

Ports:
clk  in  1  system clock; all logic on rising edge.
clr  in  1  reset, synchronous, active-high.
en  in  1  run enable.
presc  in  PRESC_W  timebase advances once every presc+1 clk cycles.
mode_in  in  1  requested mode: 0 = edge-aligned, 1 = center-aligned.
duty_wr  in  1  one-cycle strobe; writes duty_val into shadow[duty_ch].
duty_ch  in  CH_W  channel index for the write.
duty_val  in  WIDTH  duty value, 0..2^WIDTH-1.
pwm_out  out  CHANNELS  registered PWM outputs.
period_tick  out  1  one-cycle pulse at each period boundary.

Behaviour:
- Reset (clr=1), including mid-operation: on the next clock edge, every register clears.
  - Cleared registers: prescaler count, counter, direction (up), active mode (edge), all shadow and active duties, pwm_out, period_tick.
  - clr overrides en and duty_wr.
- Prescaler: pcnt increments each clk while en=1.
  - When pcnt >= presc, a tick asserts and pcnt returns to 0.
  - The >= compare makes a lowered presc take effect without waiting for a wrap.
  - presc = 0 gives a tick every clk.
- Edge mode: on each tick, cnt steps 0, 1, ..., TOP, 0, ...
  - Period = TOP+1 = 2^WIDTH - 1 ticks.
  - Boundary = the tick where cnt moves from TOP to 0.
- Center mode: on each tick, cnt steps 0..TOP going up, holds TOP for one extra tick while the direction flips, then runs TOP..0 going down, with one extra tick at 0.
  - Every value appears exactly twice per period.
  - Period = 2*(TOP+1) ticks.
  - Boundary = the tick where cnt moves from the second 0 to 1, direction up.
- At a boundary, in the same clk edge:
  - active_duty[i] <= shadow[i] for every channel, and active mode <= mode_in.
  - period_tick = 1 for exactly that one clk.
  - A mode change therefore always takes effect at a period start, with cnt = 0 and direction up.
- Duty writes:
  - shadow[duty_ch] <= duty_val when duty_wr=1, at any time.
  - A duty_ch value >= CHANNELS is ignored.
  - A write in the same cycle as a boundary lands in shadow only; the boundary loads the old shadow value, and the new value applies from the following period.
- Output: pwm_out[i] <= en & (cnt < active_duty[i]), registered, so the output lags cnt by one clk.
  - High time = duty ticks per period in edge mode, and 2*duty ticks in center mode.
  - duty = 0 gives a constant 0.
  - duty >= TOP+1 (i.e. 2^WIDTH-1) gives a constant 1, with no glitch at the boundary.
- en = 0:
  - pcnt, cnt and direction are held at reset values; pwm_out = 0 and period_tick = 0.
  - active_duty and active mode track shadow and mode_in continuously.
  - Shadow writes are still accepted.
  - When en rises, the first period starts at cnt = 0 without a period_tick; the values already in the active registers apply.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1;
  - a function computing TOP from WIDTH;
  - a direction enum DIR_UP / DIR_DOWN.
- One sub-module, pwm_timebase, contains the prescaler, counter, direction and hold-tick FSM (states UP, HOLD_TOP, DOWN, HOLD_ZERO), plus boundary/period_tick generation.
- pwm_multi instantiates pwm_timebase and a generate loop of per-channel shadow/active/compare registers.

Test Plan:
All scenarios use WIDTH=8, CHANNELS=4, presc=0 unless stated.
1. Reset: hold clr=1 for 3 clk with en=1 -> pwm_out=4'b0000 and period_tick=0. After release, the first period_tick comes 255 clk later.
2. Edge mode: shadow ch0=128, ch1=0, ch2=255, ch3=1; en=1 -> per 255-clk period, ch0 is high for 128 clk, ch1 is constant 0, ch2 is constant 1, ch3 is high for 1 clk starting 1 clk after period_tick.
3. Shadow timing: write ch0=64 at 100 clk into a period, and write ch1=50 in the exact cycle of period_tick -> ch0 stays at 128 until the next boundary and then goes to 64. ch1 takes effect one period later.
4. Center mode: set mode_in=1 and ch0=100 -> after the next boundary, the period is 510 clk. ch0 is high for 200 contiguous clk centered on the cnt=0 turnaround, and low for 310 clk centered on TOP.
5. Prescaler: presc=3, edge mode -> period_tick every 1020 clk. Lowering presc to 1 while pcnt=2 gives a tick on the next clk.
6. Mid-operation reset and en: pulse clr for 1 clk while ch0 is high -> pwm_out=0 on the next edge and all shadows read back 0. Dropping en gives the same output result but shadows are retained.
